gcd_controller: RTL and testbench

//  FSM sequencer for the subtract-based GCD datapath (A/B PIPO registers, x/y/bus MUXes, SUBTRACT, COMP).

---
 rtl/gcd_controller_pkg.sv | 24 ++
 rtl/gcd_controller_iter_counter.sv | 27 ++
 rtl/gcd_controller.sv | 146 ++++++++++++++
 tb/tb_gcd_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_controller_pkg.sv
// Shared definitions for the subtract-based GCD controller: FSM state
// encoding and the mux select constants used to drive the datapath.
package gcd_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CMP    = 3'd3,
    SUB_A  = 3'd4,
    SUB_B  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  // x/y mux selects: which register feeds the subtractor operand
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // bus mux selects: operand input or subtractor result
  localparam logic SEL_DATA = 1'b1;
  localparam logic SEL_SUB  = 1'b0;

endpackage

// File: rtl/gcd_controller_iter_counter.sv
// Iteration counter for the GCD controller. Cleared when a new pair of
// operands has been loaded, incremented once per subtract step, and held
// at MAX_ITER so a non-converging run cannot wrap back into range.
module gcd_iter_counter #(
  parameter int MAX_ITER = 1000,
  parameter int ITER_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ITER_W-1:0] count,
  output logic              at_max
);

  assign at_max = (count == ITER_W'(MAX_ITER));

  // Count subtract steps, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gcd_controller.sv
// Sequencer for the subtract-based GCD datapath. Loads A then B from the
// data bus, then alternates compare / subtract until the registers match.
// A step budget of MAX_ITER subtracts guards against operands that never
// converge (e.g. a zero), and inconsistent compare flags are reported too.
// Optional feature: define GCD_CTRL_ITER_OUT_EN to expose iter_count, the
// step count of the most recently finished operation.
module gcd_controller
  import gcd_controller_pkg::*;
#(
  parameter int MAX_ITER = 1000,
  parameter int ITER_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lt,
  input  logic gt,
  input  logic eq,
  output logic ldA,
  output logic ldB,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic done,
  output logic error
`ifdef GCD_CTRL_ITER_OUT_EN
  ,
  output logic [ITER_W-1:0] iter_count
`endif
);

  state_t state_q;
  state_t state_d;

  logic              clear_count;
  logic              inc_count;
  logic [ITER_W-1:0] count;
  logic              at_max;

  assign clear_count = (state_q == LOAD_B);
  assign inc_count   = (state_q == SUB_A) || (state_q == SUB_B);

  gcd_iter_counter #(
    .MAX_ITER(MAX_ITER),
    .ITER_W  (ITER_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_count),
    .inc   (inc_count),
    .count (count),
    .at_max(at_max)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and Moore output decode from the registered state
  always_comb begin
    state_d = state_q;
    ldA     = 1'b0;
    ldB     = 1'b0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    sel_in  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        ldA     = 1'b1;
        sel_in  = SEL_DATA;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        ldB     = 1'b1;
        sel_in  = SEL_DATA;
        state_d = CMP;
      end
      CMP: begin
        if (at_max && !eq) begin
          state_d = ERROR;
        end else if (eq) begin
          state_d = DONE;
        end else if (gt) begin
          state_d = SUB_A;
        end else if (lt) begin
          state_d = SUB_B;
        end else begin
          state_d = ERROR;
        end
      end
      SUB_A: begin
        sel1    = SEL_A;
        sel2    = SEL_B;
        sel_in  = SEL_SUB;
        ldA     = 1'b1;
        state_d = CMP;
      end
      SUB_B: begin
        sel1    = SEL_B;
        sel2    = SEL_A;
        sel_in  = SEL_SUB;
        ldB     = 1'b1;
        state_d = CMP;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        error   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef GCD_CTRL_ITER_OUT_EN
  // Snapshot the step count as the operation finishes, either way
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_count <= '0;
    end else if ((state_q == CMP) && ((state_d == DONE) || (state_d == ERROR))) begin
      iter_count <= count;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller driving a small behavioural GCD datapath.
// Expected results are computed from the operands when an operation is
// launched, queued, and compared when done or error appears.
module tb_gcd_controller;

  localparam int MAX_ITER = 16;
  localparam int ITER_W   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        lt, gt, eq;
  logic        ldA, ldB, sel1, sel2, sel_in, busy, done, error;
  logic [15:0] data_in;
  logic [15:0] a_reg, b_reg;
  logic [15:0] x_val, y_val, sub_val, bus_val;
  logic        force_en;
  logic [2:0]  forced_flags;
  logic [7:0]  outs;
`ifdef GCD_CTRL_ITER_OUT_EN
  logic [ITER_W-1:0] iter_count;
`endif

  typedef struct {
    bit is_err;
    int latency;
    int gcd;
    int steps;
  } exp_t;

  exp_t sbq[$];
  int   testsRun = 0;
  int   failCount = 0;

  gcd_controller #(
    .MAX_ITER(MAX_ITER),
    .ITER_W  (ITER_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq),
    .ldA   (ldA),
    .ldB   (ldB),
    .sel1  (sel1),
    .sel2  (sel2),
    .sel_in(sel_in),
    .busy  (busy),
    .done  (done),
    .error (error)
`ifdef GCD_CTRL_ITER_OUT_EN
    ,
    .iter_count(iter_count)
`endif
  );

  assign outs    = {ldA, ldB, sel1, sel2, sel_in, busy, done, error};
  assign x_val   = sel1 ? a_reg : b_reg;
  assign y_val   = sel2 ? a_reg : b_reg;
  assign sub_val = x_val - y_val;
  assign bus_val = sel_in ? data_in : sub_val;
  assign lt      = force_en ? forced_flags[2] : (a_reg < b_reg);
  assign gt      = force_en ? forced_flags[1] : (a_reg > b_reg);
  assign eq      = force_en ? forced_flags[0] : (a_reg == b_reg);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (ldA) a_reg <= bus_val;
    if (ldB) b_reg <= bus_val;
  end

  // Overall time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkValue(input string tag, input int obs, input int expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t modelOp(input int a_in, input int b_in, input bit f_en,
                                   input logic [2:0] f_flags);
    exp_t e;
    int a = a_in;
    int b = b_in;
    int n = 0;
    e.gcd = a_in;
    if (f_en) begin
      e.is_err = !f_flags[0];
    end else begin
      while (1) begin
        if (a == b) begin
          e.is_err = 1'b0;
          e.gcd    = a;
          break;
        end
        if (n == MAX_ITER) begin
          e.is_err = 1'b1;
          break;
        end
        if (a > b) a = a - b;
        else b = b - a;
        n++;
      end
    end
    e.steps   = n;
    e.latency = 4 + 2 * n;
    return e;
  endfunction

  // Called at an IDLE negedge; returns at the LOAD_B negedge (cycle 2)
  task automatic applyStimulus(input int a, input int b, input bit expectResult,
                               input bit holdStart);
    start   = 1'b1;
    data_in = 16'(a);
    if (expectResult) sbq.push_back(modelOp(a, b, force_en, forced_flags));
    @(negedge clk);
    start   = holdStart;
    data_in = 16'(a);
    @(negedge clk);
    data_in = 16'(b);
  endtask

  // Waits for done/error, checks it against the queue, ends at the IDLE negedge
  task automatic checkOutput(input string tag);
    exp_t e;
    int   cycles = 2;
    bit   seen = 1'b0;
    checkValue({tag, "_queued"}, int'(sbq.size() != 0), 1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    while (cycles < 400) begin
      if (done || error) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    checkValue({tag, "_seen"}, int'(seen), 1);
    if (!seen) return;
    checkValue({tag, "_latency"}, cycles, e.latency);
    checkValue({tag, "_error"}, int'(error), int'(e.is_err));
    checkValue({tag, "_done"}, int'(done), int'(!e.is_err));
    if (!e.is_err) checkValue({tag, "_aout"}, int'(a_reg), e.gcd);
`ifdef GCD_CTRL_ITER_OUT_EN
    checkValue({tag, "_iter"}, int'(iter_count), e.steps);
`endif
    @(negedge clk);
    checkValue({tag, "_idle_after"}, int'({busy, done, error}), 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    data_in      = '0;
    force_en     = 1'b0;
    forced_flags = 3'b000;
    repeat (2) @(negedge clk);
    checkValue("reset_outputs", int'(outs), 0);
`ifdef GCD_CTRL_ITER_OUT_EN
    checkValue("reset_iter", int'(iter_count), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 12/8: one SUB_A, one SUB_B
    applyStimulus(12, 8, 1'b1, 1'b0);
    checkOutput("gcd_12_8");

    // Equal operands go straight to DONE
    applyStimulus(35, 35, 1'b1, 1'b0);
    checkOutput("gcd_35_35");

    applyStimulus(100, 75, 1'b1, 1'b0);
    checkOutput("gcd_100_75");

    // Zero operand never converges: timeout error
    applyStimulus(143, 0, 1'b1, 1'b0);
    checkOutput("timeout_143_0");

    applyStimulus(0, 5, 1'b1, 1'b0);
    checkOutput("timeout_0_5");

    // Reset during SUB_B aborts the operation
    applyStimulus(7, 21, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkValue("in_sub_b", int'({ldB, sel2, sel_in, sel1}), 4'b1100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkValue("abort_outputs", int'(outs), 0);
    applyStimulus(9, 6, 1'b1, 1'b0);
    checkOutput("gcd_9_6_after_abort");

    // start held high: second run only after IDLE is revisited
    applyStimulus(20, 15, 1'b1, 1'b1);
    checkOutput("held_start_first");
    applyStimulus(21, 14, 1'b1, 1'b0);
    checkOutput("held_start_second");

    // No compare flag set: illegal, error
    force_en     = 1'b1;
    forced_flags = 3'b000;
    applyStimulus(10, 4, 1'b1, 1'b0);
    checkOutput("no_flags");

    // gt and eq together: eq wins
    forced_flags = 3'b011;
    applyStimulus(10, 4, 1'b1, 1'b0);
    checkOutput("eq_priority");
    force_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
